// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
// Optional feature macro used by the top: HAZARD_PERF_COUNTERS_EN.
package hazard_ctrl_pkg;

    localparam int REG_INDEX_WIDTH = 5;
    localparam int BUSY_CNT_WIDTH  = 8;
    localparam int SCRUB_CNT_WIDTH = 4;

    localparam logic [REG_INDEX_WIDTH-1:0] ZERO_REG_INDEX = '0;
    localparam logic [BUSY_CNT_WIDTH-1:0]  BUSY_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        SCRUB    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HUNG     = 2'd3
    } ctrl_state_t;

    // Field order (MSB first) is also the bit order of the packed constants below.
    typedef struct packed {
        logic pcDontUpdate;
        logic ifIdDontUpdate;
        logic ifIdFlush;
        logic idExDontUpdate;
        logic idExFlush;
        logic exMemDontUpdate;
    } barrier_ctrl_t;

    localparam barrier_ctrl_t CTRL_NONE   = barrier_ctrl_t'(6'b000000);
    localparam barrier_ctrl_t CTRL_SCRUB  = barrier_ctrl_t'(6'b101010);
    localparam barrier_ctrl_t CTRL_FREEZE = barrier_ctrl_t'(6'b110101);
    localparam barrier_ctrl_t CTRL_BRANCH = barrier_ctrl_t'(6'b001010);
    localparam barrier_ctrl_t CTRL_STALL  = barrier_ctrl_t'(6'b110010);

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX. Register x0 never produces a hazard.
module load_use_detector
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] idLHSRegisterIndex,
    input  logic [4:0] idRHSRegisterIndex,
    input  logic       idUsesLHS,
    input  logic       idUsesRHS,
    input  logic       exMemRead,
    input  logic [4:0] exWriteRegisterIndex,
    output logic       hazard
);

    logic lhsMatch;
    logic rhsMatch;
    logic writesRealReg;

    always_comb begin
        lhsMatch      = idUsesLHS && (idLHSRegisterIndex == exWriteRegisterIndex);
        rhsMatch      = idUsesRHS && (idRHSRegisterIndex == exWriteRegisterIndex);
        writesRealReg = (exWriteRegisterIndex != ZERO_REG_INDEX);
        hazard        = exMemRead && writesRealReg && (lhsMatch || rhsMatch);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central barrier sequencer: reset scrub, load-use stall, branch squash, memory freeze
// and stall watchdog. Define HAZARD_PERF_COUNTERS_EN to add stall/flush counters.
module pipeline_hazard_controller
    import hazard_ctrl_pkg::*;
#(
    parameter int RESET_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT        = 64
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idLHSRegisterIndex,
    input  logic [4:0]  idRHSRegisterIndex,
    input  logic        idUsesLHS,
    input  logic        idUsesRHS,
    input  logic        exMemRead,
    input  logic [4:0]  exWriteRegisterIndex,
    input  logic        exBranchTaken,
    input  logic        memBusy,
    output logic        pcDontUpdate,
    output logic        ifIdDontUpdate,
    output logic        ifIdFlush,
    output logic        idExDontUpdate,
    output logic        idExFlush,
    output logic        exMemDontUpdate,
    output logic        memTimeout,
    output logic [1:0]  ctrlState
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushEvents
`endif
);

    localparam logic [SCRUB_CNT_WIDTH-1:0] SCRUB_LAST    = SCRUB_CNT_WIDTH'(RESET_FLUSH_CYCLES - 1);
    localparam logic [BUSY_CNT_WIDTH-1:0]  TIMEOUT_COUNT = BUSY_CNT_WIDTH'(MEM_TIMEOUT);

    ctrl_state_t                state;
    ctrl_state_t                stateNext;
    logic [SCRUB_CNT_WIDTH-1:0] scrubCnt;
    logic [SCRUB_CNT_WIDTH-1:0] scrubCntNext;
    logic [BUSY_CNT_WIDTH-1:0]  busyCnt;
    logic [BUSY_CNT_WIDTH-1:0]  busyCntNext;
    logic [BUSY_CNT_WIDTH-1:0]  busyInc;
    logic                       memTimeoutQ;
    logic                       memTimeoutNext;
    logic                       loadUse;
    logic                       loadUseStall;
    barrier_ctrl_t              runCtrl;
    barrier_ctrl_t              ctrl;

    load_use_detector u_loadUse (
        .idLHSRegisterIndex   (idLHSRegisterIndex),
        .idRHSRegisterIndex   (idRHSRegisterIndex),
        .idUsesLHS            (idUsesLHS),
        .idUsesRHS            (idUsesRHS),
        .exMemRead            (exMemRead),
        .exWriteRegisterIndex (exWriteRegisterIndex),
        .hazard               (loadUse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCRUB;
            scrubCnt    <= '0;
            busyCnt     <= '0;
            memTimeoutQ <= 1'b0;
        end else begin
            state       <= stateNext;
            scrubCnt    <= scrubCntNext;
            busyCnt     <= busyCntNext;
            memTimeoutQ <= memTimeoutNext;
        end
    end

    always_comb begin
        stateNext      = state;
        scrubCntNext   = scrubCnt;
        busyCntNext    = busyCnt;
        memTimeoutNext = memTimeoutQ;
        busyInc        = (busyCnt == BUSY_CNT_MAX) ? busyCnt : busyCnt + 1'b1;
        case (state)
            SCRUB: begin
                scrubCntNext = scrubCnt + 1'b1;
                if (scrubCnt == SCRUB_LAST) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (memBusy) begin
                    stateNext   = MEM_WAIT;
                    busyCntNext = BUSY_CNT_WIDTH'(1);
                end else begin
                    busyCntNext = '0;
                end
            end
            MEM_WAIT: begin
                if (memBusy) begin
                    busyCntNext = busyInc;
                    // busyCnt counts completed busy cycles, so reaching the limit here
                    // means memory has been busy for MEM_TIMEOUT consecutive cycles.
                    if (busyInc >= TIMEOUT_COUNT) begin
                        stateNext      = HUNG;
                        memTimeoutNext = 1'b1;
                    end
                end else begin
                    stateNext   = RUN;
                    busyCntNext = '0;
                end
            end
            HUNG: begin
                stateNext = HUNG;
            end
            default: begin
                stateNext = SCRUB;
            end
        endcase
    end

    // A taken branch squashes the ID instruction, so it outranks the load-use stall.
    always_comb begin
        loadUseStall = 1'b0;
        if (memBusy) begin
            runCtrl = CTRL_FREEZE;
        end else if (exBranchTaken) begin
            runCtrl = CTRL_BRANCH;
        end else if (loadUse) begin
            runCtrl      = CTRL_STALL;
            loadUseStall = 1'b1;
        end else begin
            runCtrl = CTRL_NONE;
        end
    end

    always_comb begin
        ctrl = CTRL_NONE;
        if (rst) begin
            ctrl = CTRL_SCRUB;
        end else begin
            case (state)
                SCRUB:    ctrl = CTRL_SCRUB;
                RUN:      ctrl = runCtrl;
                MEM_WAIT: ctrl = memBusy ? CTRL_FREEZE : runCtrl;
                HUNG:     ctrl = CTRL_FREEZE;
                default:  ctrl = CTRL_SCRUB;
            endcase
        end
    end

    assign pcDontUpdate    = ctrl.pcDontUpdate;
    assign ifIdDontUpdate  = ctrl.ifIdDontUpdate;
    assign ifIdFlush       = ctrl.ifIdFlush;
    assign idExDontUpdate  = ctrl.idExDontUpdate;
    assign idExFlush       = ctrl.idExFlush;
    assign exMemDontUpdate = ctrl.exMemDontUpdate;
    assign memTimeout      = memTimeoutQ && !rst;
    assign ctrlState       = state;

`ifdef HAZARD_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles <= '0;
            flushEvents <= '0;
        end else begin
            if ((state == RUN && loadUseStall) || state == MEM_WAIT) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (state == RUN && exBranchTaken) begin
                flushEvents <= flushEvents + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: vector table, random RUN
// vectors and hand-written multi-cycle sequences, all through an expected queue.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] idLHSRegisterIndex;
    logic [4:0] idRHSRegisterIndex;
    logic       idUsesLHS;
    logic       idUsesRHS;
    logic       exMemRead;
    logic [4:0] exWriteRegisterIndex;
    logic       exBranchTaken;
    logic       memBusy;
    logic       pcDontUpdate;
    logic       ifIdDontUpdate;
    logic       ifIdFlush;
    logic       idExDontUpdate;
    logic       idExFlush;
    logic       exMemDontUpdate;
    logic       memTimeout;
    logic [1:0] ctrlState;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stallCycles;
    logic [31:0] flushEvents;
`endif

    // Expected control word bit order: {pc, ifIdHold, ifIdFlush, idExHold, idExFlush, exMemHold}
    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_RESET  = 6'b101010;
    localparam logic [5:0] C_FREEZE = 6'b110101;
    localparam logic [5:0] C_BRANCH = 6'b001010;
    localparam logic [5:0] C_STALL  = 6'b110010;

    localparam logic [1:0] ST_SCRUB = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HUNG  = 2'd3;

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [4:0] lhs;
        logic [4:0] rhs;
        logic       usesL;
        logic       usesR;
        logic       load;
        logic [4:0] wr;
        logic       br;
        logic [5:0] expCtrl;
    } vec_t;

    vec_t vecs[10];

    pipeline_hazard_controller dut (
        .clk                  (clk),
        .rst                  (rst),
        .idLHSRegisterIndex   (idLHSRegisterIndex),
        .idRHSRegisterIndex   (idRHSRegisterIndex),
        .idUsesLHS            (idUsesLHS),
        .idUsesRHS            (idUsesRHS),
        .exMemRead            (exMemRead),
        .exWriteRegisterIndex (exWriteRegisterIndex),
        .exBranchTaken        (exBranchTaken),
        .memBusy              (memBusy),
        .pcDontUpdate         (pcDontUpdate),
        .ifIdDontUpdate       (ifIdDontUpdate),
        .ifIdFlush            (ifIdFlush),
        .idExDontUpdate       (idExDontUpdate),
        .idExFlush            (idExFlush),
        .exMemDontUpdate      (exMemDontUpdate),
        .memTimeout           (memTimeout),
        .ctrlState            (ctrlState)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .stallCycles          (stallCycles),
        .flushEvents          (flushEvents)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive(input logic [4:0] lhs, input logic [4:0] rhs, input logic ul,
                         input logic ur, input logic ld, input logic [4:0] wr,
                         input logic br, input logic busy);
        idLHSRegisterIndex   = lhs;
        idRHSRegisterIndex   = rhs;
        idUsesLHS            = ul;
        idUsesRHS            = ur;
        exMemRead            = ld;
        exWriteRegisterIndex = wr;
        exBranchTaken        = br;
        memBusy              = busy;
    endtask

    task automatic drive_idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic push_exp(input logic mt, input logic [1:0] st, input logic [5:0] c);
        exp_q.push_back({mt, st, c});
    endtask

    // Scoreboard: sample at the falling edge, compare against the queue head,
    // then advance to just after the next rising edge.
    task automatic check_cycle(input string name);
        logic [8:0] got;
        logic [8:0] e;
        @(negedge clk);
        got = {memTimeout, ctrlState, pcDontUpdate, ifIdDontUpdate, ifIdFlush,
               idExDontUpdate, idExFlush, exMemDontUpdate};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: no expected entry queued, got %b", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL %s: got mt=%b st=%0d ctrl=%b, want mt=%b st=%0d ctrl=%b",
                         name, got[8], got[7:6], got[5:0], e[8], e[7:6], e[5:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] model_run(input logic [4:0] lhs, input logic [4:0] rhs,
                                             input logic ul, input logic ur, input logic ld,
                                             input logic [4:0] wr, input logic br);
        logic dependent;
        dependent = (ul && lhs == wr) || (ur && rhs == wr);
        if (br) return C_BRANCH;
        if (ld && wr != 5'd0 && dependent) return C_STALL;
        return C_NONE;
    endfunction

    initial begin
        vecs[0] = '{5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, C_STALL};
        vecs[1] = '{5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, C_NONE};
        vecs[2] = '{5'd1,  5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, C_STALL};
        vecs[3] = '{5'd1,  5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, C_NONE};
        vecs[4] = '{5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, C_NONE};
        vecs[5] = '{5'd5,  5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, C_BRANCH};
        vecs[6] = '{5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, C_BRANCH};
        vecs[7] = '{5'd31, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, C_STALL};
        vecs[8] = '{5'd5,  5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, C_NONE};
        vecs[9] = '{5'd31, 5'd0, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, C_NONE};

        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;

        // Reset and scrub; memBusy and a hazard during scrub must be ignored
        push_exp(1'b0, ST_SCRUB, C_RESET);
        check_cycle("reset_hold");
        rst = 1'b0;
        push_exp(1'b0, ST_SCRUB, C_RESET);
        check_cycle("scrub_0");
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        push_exp(1'b0, ST_SCRUB, C_RESET);
        check_cycle("scrub_1");
        drive_idle();
        push_exp(1'b0, ST_RUN, C_NONE);
        check_cycle("run_entry");

        // Stall accounting sequence: one load-use, three busy cycles, two branches
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        push_exp(1'b0, ST_RUN, C_STALL);
        check_cycle("perf_loaduse");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        push_exp(1'b0, ST_RUN, C_FREEZE);
        check_cycle("perf_busy_0");
        push_exp(1'b0, ST_WAIT, C_FREEZE);
        check_cycle("perf_busy_1");
        push_exp(1'b0, ST_WAIT, C_FREEZE);
        check_cycle("perf_busy_2");
        drive_idle();
        push_exp(1'b0, ST_WAIT, C_NONE);
        check_cycle("perf_release");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        push_exp(1'b0, ST_RUN, C_BRANCH);
        check_cycle("perf_branch_0");
        push_exp(1'b0, ST_RUN, C_BRANCH);
        check_cycle("perf_branch_1");
        drive_idle();
`ifdef HAZARD_PERF_COUNTERS_EN
        tests++;
        if (stallCycles !== 32'd4) begin
            fails++;
            $display("FAIL perf_stallCycles: got %0d, want 4", stallCycles);
        end
        tests++;
        if (flushEvents !== 32'd2) begin
            fails++;
            $display("FAIL perf_flushEvents: got %0d, want 2", flushEvents);
        end
`endif

        // Vector table in RUN
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].lhs, vecs[i].rhs, vecs[i].usesL, vecs[i].usesR,
                  vecs[i].load, vecs[i].wr, vecs[i].br, 1'b0);
            push_exp(1'b0, ST_RUN, vecs[i].expCtrl);
            check_cycle($sformatf("vec_%0d", i));
        end

        // Random RUN vectors over a small register range so matches are frequent
        for (int i = 0; i < 40; i++) begin
            logic [4:0] l, r, w;
            logic ul, ur, ld, br;
            l  = 5'($urandom_range(0, 3));
            r  = 5'($urandom_range(0, 3));
            w  = 5'($urandom_range(0, 3));
            ul = 1'($urandom_range(0, 1));
            ur = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 4) == 0);
            drive(l, r, ul, ur, ld, w, br, 1'b0);
            push_exp(1'b0, ST_RUN, model_run(l, r, ul, ur, ld, w, br));
            check_cycle($sformatf("rand_%0d", i));
        end

        // Memory wait with a taken branch held: freeze, then flush on release
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        push_exp(1'b0, ST_RUN, C_FREEZE);
        check_cycle("memwait_0");
        push_exp(1'b0, ST_WAIT, C_FREEZE);
        check_cycle("memwait_1");
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        push_exp(1'b0, ST_WAIT, C_FREEZE);
        check_cycle("memwait_2");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        push_exp(1'b0, ST_WAIT, C_BRANCH);
        check_cycle("memwait_release");
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        push_exp(1'b0, ST_RUN, C_STALL);
        check_cycle("memwait_back_run");

        // One cycle short of the watchdog limit: no timeout
        for (int i = 1; i <= 63; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            push_exp(1'b0, (i == 1) ? ST_RUN : ST_WAIT, C_FREEZE);
            check_cycle($sformatf("busy63_%0d", i));
        end
        drive_idle();
        push_exp(1'b0, ST_WAIT, C_NONE);
        check_cycle("busy63_release");
        push_exp(1'b0, ST_RUN, C_NONE);
        check_cycle("busy63_run");

        // Watchdog: 64 consecutive busy cycles
        for (int i = 1; i <= 64; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            push_exp(1'b0, (i == 1) ? ST_RUN : ST_WAIT, C_FREEZE);
            check_cycle($sformatf("busy64_%0d", i));
        end
        push_exp(1'b1, ST_HUNG, C_FREEZE);
        check_cycle("hung_busy");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        push_exp(1'b1, ST_HUNG, C_FREEZE);
        check_cycle("hung_branch");
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        push_exp(1'b1, ST_HUNG, C_FREEZE);
        check_cycle("hung_loaduse");

        // Reset out of HUNG clears the watchdog flag and rescrubs
        rst = 1'b1;
        push_exp(1'b0, ST_HUNG, C_RESET);
        check_cycle("hung_rst");
        rst = 1'b0;
        push_exp(1'b0, ST_SCRUB, C_RESET);
        check_cycle("rescrub_0");
        push_exp(1'b0, ST_SCRUB, C_RESET);
        check_cycle("rescrub_1");
        push_exp(1'b0, ST_RUN, C_STALL);
        check_cycle("rescrub_run");
        drive_idle();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
